// File: rtl/spi_cmd_ram.sv
// rtl/spi_cmd_ram.sv - command-decoded single-clock RAM with ready/valid read return
// Optional feature: define RAM_AUTOINC_EN to post-increment wr_addr/rd_addr on data accesses.
module spi_cmd_ram #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 8,
    parameter int MEM_DEPTH = 2 ** ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_valid,
    output logic              rx_ready,
    input  logic [DATA_W+1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              addr_err
);

    if (ADDR_W > DATA_W) begin : g_bad_addr_w
        $error("spi_cmd_ram: ADDR_W must not exceed DATA_W");
    end
    if (MEM_DEPTH < 1 || MEM_DEPTH > 2 ** ADDR_W) begin : g_bad_depth
        $error("spi_cmd_ram: MEM_DEPTH out of range");
    end

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    // One extra bit so MEM_DEPTH == 2**ADDR_W is representable.
    localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(MEM_DEPTH);
    localparam logic [ADDR_W-1:0] LAST_L  = ADDR_W'(MEM_DEPTH - 1);

    typedef enum logic {EMPTY, FULL} out_state_t;

    out_state_t        state;
    logic [DATA_W-1:0] mem [MEM_DEPTH];
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rd_addr;

    logic [1:0]        cmd;
    logic [DATA_W-1:0] payload;
    logic [ADDR_W-1:0] addr;
    logic              accept;
    logic              wr_ok;
    logic              rd_ok;

    assign cmd      = din[DATA_W+1:DATA_W];
    assign payload  = din[DATA_W-1:0];
    assign addr     = payload[ADDR_W-1:0];
    assign tx_valid = (state == FULL);
    assign rx_ready = ~tx_valid | tx_ready;
    assign accept   = rx_valid & rx_ready;
    assign wr_ok    = {1'b0, wr_addr} < DEPTH_L;
    assign rd_ok    = {1'b0, rd_addr} < DEPTH_L;

    function automatic logic [ADDR_W-1:0] next_ptr(input logic [ADDR_W-1:0] p);
        return (p >= LAST_L) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= EMPTY;
            dout     <= '0;
            addr_err <= 1'b0;
            wr_addr  <= '0;
            rd_addr  <= '0;
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            addr_err <= 1'b0;
            if (state == FULL && tx_ready) begin
                state <= EMPTY;
            end
            if (accept) begin
                case (cmd)
                    CMD_WR_ADDR: wr_addr <= addr;
                    CMD_WR_DATA: begin
                        if (wr_ok) begin
                            mem[wr_addr] <= payload;
                        end else begin
                            addr_err <= 1'b1;
                        end
`ifdef RAM_AUTOINC_EN
                        wr_addr <= next_ptr(wr_addr);
`endif
                    end
                    CMD_RD_ADDR: rd_addr <= addr;
                    CMD_RD_DATA: begin
                        // Overrides the EMPTY transition above when the word is taken this edge.
                        dout     <= rd_ok ? mem[rd_addr] : '0;
                        state    <= FULL;
                        addr_err <= ~rd_ok;
`ifdef RAM_AUTOINC_EN
                        rd_addr <= next_ptr(rd_addr);
`endif
                    end
                    default: ;
                endcase
            end
        end
    end

`ifndef RAM_AUTOINC_EN
    logic unused_next_ptr;
    assign unused_next_ptr = ^next_ptr(wr_addr);
`endif

endmodule
